// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with tear-free frame commit,
// leading-zero blanking and per-digit blink.
module seg7_scan_driver #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     blink_en,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an_out,
  output logic                  load_ack,
  output logic                  frame_tick
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] PRE_TOP = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_TOP = IW'(DIGITS - 1);
  localparam logic [BW-1:0] FRM_TOP = BW'(BLINK_DIV - 1);

  logic [PW-1:0]       presc;
  logic [IW-1:0]       idx;
  logic [BW-1:0]       fcnt;
  logic                phase;
  logic                pend_flag;
  logic [4*DIGITS-1:0] pend_val;
  logic [DIGITS-1:0]   pend_dp;
  logic [4*DIGITS-1:0] disp_val;
  logic [DIGITS-1:0]   disp_dp;

  logic                pre_wrap;
  logic                frame_end;
  logic [3:0]          nib;
  logic                dp_bit;
  logic                blk;
  logic                lz;
  logic                lz_zero;
  logic [DIGITS-1:0]   an_nxt;
  logic [6:0]          seg_nxt;
  logic                dp_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      4'hF: hex7 = 7'h0E;
      default: hex7 = 7'h36;
    endcase
  endfunction

  assign pre_wrap  = (presc == PRE_TOP);
  assign frame_end = pre_wrap && (idx == IDX_TOP);

  // Walk from the top digit down so lz_zero means "this and all higher are 0".
  always_comb begin
    nib     = 4'h0;
    dp_bit  = 1'b0;
    blk     = 1'b0;
    lz      = 1'b0;
    lz_zero = 1'b1;
    an_nxt  = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz_zero = lz_zero && (disp_val[4*i +: 4] == 4'h0);
      if (idx == IW'(i)) begin
        nib       = disp_val[4*i +: 4];
        dp_bit    = disp_dp[i];
        blk       = blink_en[i];
        lz        = lz_zero && (i != 0);
        an_nxt[i] = 1'b0;
      end
    end
  end

  always_comb begin
    seg_nxt = hex7(nib);
    dp_nxt  = ~dp_bit;
    if (phase && blk) begin
      seg_nxt = 7'h7F;
      dp_nxt  = 1'b1;
    end else if (blank_lz && lz) begin
      seg_nxt = 7'h7F;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc      <= '0;
      idx        <= '0;
      fcnt       <= '0;
      phase      <= 1'b0;
      pend_flag  <= 1'b0;
      pend_val   <= '0;
      pend_dp    <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      an_out     <= '1;
      seg_out    <= 7'h7F;
      dp_out     <= 1'b1;
      load_ack   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      presc      <= pre_wrap ? '0 : presc + 1'b1;
      an_out     <= an_nxt;
      seg_out    <= seg_nxt;
      dp_out     <= dp_nxt;
      load_ack   <= load;
      frame_tick <= frame_end;
      if (pre_wrap)
        idx <= (idx == IDX_TOP) ? '0 : idx + 1'b1;
      if (frame_end) begin
        if (pend_flag) begin
          disp_val <= pend_val;
          disp_dp  <= pend_dp;
        end
        pend_flag <= 1'b0;
        fcnt      <= (fcnt == FRM_TOP) ? '0 : fcnt + 1'b1;
        if (fcnt == FRM_TOP)
          phase <= ~phase;
      end
      // A load on the commit edge wins the flag and waits a frame.
      if (load) begin
        pend_val  <= value_in;
        pend_dp   <= dp_in;
        pend_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIGITS=4,
// SCAN_DIV=4, BLINK_DIV=2.
module tb_seg7_scan_driver;

  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  blink_en;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic        load_ack;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_an [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0] seg_w [4];
  logic [6:0] seg_v [4];

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .DIGITS(DIGITS),
    .SCAN_DIV(SCAN_DIV),
    .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .value_in(value_in),
    .dp_in(dp_in),
    .blank_lz(blank_lz),
    .blink_en(blink_en),
    .seg_out(seg_out),
    .dp_out(dp_out),
    .an_out(an_out),
    .load_ack(load_ack),
    .frame_tick(frame_tick)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    step();
    while (frame_tick !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    checks++;
    if (frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL %s_tick_timeout: got %b want 1", tag, frame_tick);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    load = 1'b1;
    value_in = 16'hFFFF;
    dp_in = 4'hF;
    blank_lz = 1'b0;
    blink_en = 4'h0;
    repeat (3) step();
    load = 1'b0;
    checks++;
    if (an_out !== 4'hF) begin
      errors++;
      $display("FAIL rst_an: got %h want F", an_out);
    end
    checks++;
    if (seg_out !== 7'h7F) begin
      errors++;
      $display("FAIL rst_seg: got %h want 7F", seg_out);
    end
    checks++;
    if (dp_out !== 1'b1) begin
      errors++;
      $display("FAIL rst_dp: got %b want 1", dp_out);
    end
    checks++;
    if (load_ack !== 1'b0 || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL rst_pulses: got ack %b tick %b want 0 0",
               load_ack, frame_tick);
    end
    rst = 1'b1;
    step();
    checks++;
    if (an_out !== 4'hE || seg_out !== 7'h40) begin
      errors++;
      $display("FAIL rel_digit0: got an %h seg %h want E 40",
               an_out, seg_out);
    end
  endtask

  task automatic test_scan();
    int d;
    load = 1'b1;
    value_in = 16'h12AF;
    dp_in = 4'h0;
    step();
    load = 1'b0;
    checks++;
    if (load_ack !== 1'b1) begin
      errors++;
      $display("FAIL scan_ack: got %b want 1", load_ack);
    end
    step();
    checks++;
    if (load_ack !== 1'b0) begin
      errors++;
      $display("FAIL scan_ack_end: got %b want 0", load_ack);
    end
    wait_tick("scan");
    seg_w = '{7'h0E, 7'h08, 7'h24, 7'h79};
    for (int j = 1; j <= 16; j++) begin
      d = (j - 1) / 4;
      step();
      checks++;
      if (an_out !== exp_an[d] || seg_out !== seg_w[d]) begin
        errors++;
        $display("FAIL scan_c%0d: got an %h seg %h want %h %h",
                 j, an_out, seg_out, exp_an[d], seg_w[d]);
      end
      checks++;
      if (frame_tick !== (j == 16)) begin
        errors++;
        $display("FAIL scan_tick_c%0d: got %b want %b",
                 j, frame_tick, (j == 16));
      end
    end
  endtask

  task automatic test_anti_tear();
    int d;
    for (int j = 1; j <= 16; j++) begin
      d = (j - 1) / 4;
      step();
      checks++;
      if (an_out !== exp_an[d] || seg_out !== seg_w[d]) begin
        errors++;
        $display("FAIL tear_old_c%0d: got an %h seg %h want %h %h",
                 j, an_out, seg_out, exp_an[d], seg_w[d]);
      end
      if (j == 6) begin
        checks++;
        if (load_ack !== 1'b1) begin
          errors++;
          $display("FAIL tear_ack: got %b want 1", load_ack);
        end
        load = 1'b0;
      end
      if (j == 5) begin
        load = 1'b1;
        value_in = 16'h0000;
      end
    end
    for (int j = 1; j <= 16; j++) begin
      d = (j - 1) / 4;
      step();
      checks++;
      if (an_out !== exp_an[d] || seg_out !== 7'h40) begin
        errors++;
        $display("FAIL tear_new_c%0d: got an %h seg %h want %h 40",
                 j, an_out, seg_out, exp_an[d]);
      end
    end
  endtask

  task automatic test_lz();
    int d;
    blank_lz = 1'b1;
    load = 1'b1;
    value_in = 16'h0050;
    step();
    load = 1'b0;
    wait_tick("lz50");
    seg_w = '{7'h40, 7'h12, 7'h7F, 7'h7F};
    for (int j = 1; j <= 16; j++) begin
      d = (j - 1) / 4;
      step();
      checks++;
      if (seg_out !== seg_w[d]) begin
        errors++;
        $display("FAIL lz50_c%0d: got %h want %h", j, seg_out, seg_w[d]);
      end
    end
    load = 1'b1;
    value_in = 16'h0000;
    step();
    load = 1'b0;
    wait_tick("lz00");
    seg_w = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
    for (int j = 1; j <= 16; j++) begin
      d = (j - 1) / 4;
      step();
      checks++;
      if (seg_out !== seg_w[d] || dp_out !== 1'b1) begin
        errors++;
        $display("FAIL lz00_c%0d: got seg %h dp %b want %h 1",
                 j, seg_out, dp_out, seg_w[d]);
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_blink();
    int d;
    logic bl;
    logic [6:0] es;
    logic ed;
    blink_en = 4'b0001;
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    seg_v = '{7'h30, 7'h24, 7'h79, 7'h40};
    for (int f = 0; f < 8; f++) begin
      bl = ((f / 2) % 2) == 1;
      for (int j = 1; j <= 16; j++) begin
        d = (j - 1) / 4;
        step();
        es = (f == 0) ? 7'h40 : seg_v[d];
        ed = 1'b1;
        if (d == 0 && f != 0) ed = 1'b0;
        if (d == 0 && bl) begin
          es = 7'h7F;
          ed = 1'b1;
        end
        checks++;
        if (an_out !== exp_an[d] || seg_out !== es || dp_out !== ed) begin
          errors++;
          $display("FAIL blink_f%0d_c%0d: got an %h seg %h dp %b want %h %h %b",
                   f, j, an_out, seg_out, dp_out, exp_an[d], es, ed);
        end
        if (j == 16) begin
          checks++;
          if (frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL blink_tick_f%0d: got %b want 1", f, frame_tick);
          end
        end
        if (f == 0 && j == 1) begin
          load = 1'b1;
          value_in = 16'h0123;
          dp_in = 4'b0001;
        end
        if (f == 0 && j == 2) begin
          load = 1'b0;
          dp_in = 4'h0;
        end
      end
    end
    blink_en = 4'h0;
  endtask

  task automatic test_boundary_load();
    int d;
    load = 1'b1;
    value_in = 16'h5678;
    step();
    load = 1'b0;
    wait_tick("bnd");
    for (int j = 1; j <= 16; j++) begin
      step();
      if (j == 16) begin
        checks++;
        if (load_ack !== 1'b1 || frame_tick !== 1'b1) begin
          errors++;
          $display("FAIL bnd_coincide: got ack %b tick %b want 1 1",
                   load_ack, frame_tick);
        end
        load = 1'b0;
      end
      if (j == 15) begin
        load = 1'b1;
        value_in = 16'h9ABC;
      end
    end
    seg_w = '{7'h00, 7'h78, 7'h02, 7'h12};
    for (int j = 1; j <= 16; j++) begin
      d = (j - 1) / 4;
      step();
      checks++;
      if (seg_out !== seg_w[d]) begin
        errors++;
        $display("FAIL bnd_old_c%0d: got %h want %h", j, seg_out, seg_w[d]);
      end
    end
    seg_w = '{7'h46, 7'h03, 7'h08, 7'h10};
    for (int j = 1; j <= 16; j++) begin
      d = (j - 1) / 4;
      step();
      checks++;
      if (seg_out !== seg_w[d]) begin
        errors++;
        $display("FAIL bnd_new_c%0d: got %h want %h", j, seg_out, seg_w[d]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int d;
    repeat (5) step();
    load = 1'b1;
    value_in = 16'hFFFF;
    dp_in = 4'hF;
    step();
    checks++;
    if (load_ack !== 1'b1) begin
      errors++;
      $display("FAIL mid_ack: got %b want 1", load_ack);
    end
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (an_out !== 4'hF || seg_out !== 7'h7F || dp_out !== 1'b1 ||
          load_ack !== 1'b0 || frame_tick !== 1'b0) begin
        errors++;
        $display("FAIL mid_rst_%0d: got an %h seg %h dp %b ack %b tick %b want F 7F 1 0 0",
                 k, an_out, seg_out, dp_out, load_ack, frame_tick);
      end
    end
    rst = 1'b1;
    load = 1'b0;
    dp_in = 4'h0;
    step();
    checks++;
    if (an_out !== 4'hE || seg_out !== 7'h40 || dp_out !== 1'b1) begin
      errors++;
      $display("FAIL mid_rel: got an %h seg %h dp %b want E 40 1",
               an_out, seg_out, dp_out);
    end
    wait_tick("mid");
    for (int j = 1; j <= 16; j++) begin
      d = (j - 1) / 4;
      step();
      checks++;
      if (an_out !== exp_an[d] || seg_out !== 7'h40 ||
          dp_out !== 1'b1 || load_ack !== 1'b0) begin
        errors++;
        $display("FAIL mid_discard_c%0d: got an %h seg %h dp %b ack %b want %h 40 1 0",
                 j, an_out, seg_out, dp_out, load_ack, exp_an[d]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_anti_tear();
    test_lz();
    test_blink();
    test_boundary_load();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 50000, clock cycles each digit is lit; legal minimum 2.
REQ-003 Parameter BLINK_DIV, default 64, completed frames per blink half-period; legal minimum 1.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-low.
REQ-006 load  in  1  request to capture value_in/dp_in.
REQ-007 value_in  in  4*DIGITS  hex nibbles; nibble 0 (bits 3:0) is digit 0, the rightmost digit.
REQ-008 dp_in  in  DIGITS  decimal point per digit, 1 means lit.
REQ-009 blank_lz  in  1  leading-zero blanking enable.
REQ-010 blink_en  in  DIGITS  per-digit blink mask.
REQ-011 seg_out  out  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-012 dp_out  out  1  active-low decimal point.
REQ-013 an_out  out  DIGITS  active-low one-hot anode select.
REQ-014 load_ack  out  1  one-cycle pulse confirming a capture.
REQ-015 frame_tick  out  1  one-cycle pulse at each frame wrap.

Function
REQ-016 The block SHALL contain a prescaler that counts 0..SCAN_DIV-1 and wraps; its terminal count SHALL advance the digit index 0..DIGITS-1, wrapping DIGITS-1 to 0.
REQ-017 Every output SHALL be registered; an_out/seg_out/dp_out SHALL reflect the index from the previous cycle.
REQ-018 an_out SHALL drive low only the bit at the current index.
REQ-019 seg_out (hex, active-low) SHALL decode 0-F as: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
REQ-020 seg_out SHALL be 36 for any X or Z nibble.
REQ-021 When load=1 is sampled, value_in/dp_in SHALL be copied into a pending register and a pending flag set; load_ack SHALL be 1 on the following cycle only.
REQ-022 A new load while pending SHALL overwrite the pending contents; each such load SHALL produce its own load_ack.
REQ-023 On the edge where the prescaler is at terminal count and the index is DIGITS-1, the block SHALL copy pending into the display register if the flag is set, clear the flag, and pulse frame_tick on the next cycle.
REQ-024 The display SHALL never change mid-frame (no tearing).
REQ-025 If load and commit coincide, commit SHALL use the pre-edge pending contents; the new load SHALL remain pending for the next frame.
REQ-026 When blank_lz=1, a digit SHALL show seg 7F if its nibble and all higher nibbles are 0; digit 0 SHALL never be lz-blanked; dp_out SHALL be unaffected by lz blanking.
REQ-027 A frame counter SHALL count frames 0..BLINK_DIV-1 and toggle blink phase on wrap.
REQ-028 When the phase is 1, digits whose blink_en bit is 1 SHALL show seg 7F and dp_out 1; the anode SHALL still scan.
REQ-029 blank_lz and blink_en SHALL act combinationally on the live inputs; they are not captured by load.
REQ-030 Counter widths SHALL be ceil(log2(parameter)), minimum 1 bit, with no overflow at the parameter limits.

Reset
REQ-031 While rst=0 at a clock edge, the block SHALL set an_out all 1s, seg_out 7F, dp_out 1, load_ack 0, and frame_tick 0.
REQ-032 Reset SHALL also clear prescaler, index, frame counter, blink phase, pending flag, pending register, and display register.
REQ-033 Reset SHALL override a simultaneous load.
REQ-034 On the first cycle after rst returns to 1, an_out SHALL select digit 0 showing 40.
REQ-035 Reset mid-frame SHALL discard pending data with no load_ack.

Verification (DIGITS=4, SCAN_DIV=4, BLINK_DIV=2)
REQ-036 Reset: rst=0 for 3 cycles -> an_out=F, seg_out=7F, dp_out=1, load_ack=0; after release an_out=E, seg_out=40.
REQ-037 Scan and decode: load value 12AF, run to the next frame -> an_out sequence E,D,B,7, each held 4 cycles, with seg_out 0E, 08, 24, 79; frame_tick every 16 cycles; load_ack 1 cycle after load.
REQ-038 Anti-tear: load 0000 while digit 1 is lit -> digits 2 and 3 still show the old value; all digits show 40 from the next frame.
REQ-039 Leading-zero blanking: blank_lz=1, value 0050 -> digits 3 and 2 show 7F, digit 1 shows 12, digit 0 shows 40; value 0000 -> only digit 0 shows 40.
REQ-040 Blink and dp: blink_en=0001, dp_in=0001 -> digit 0 shows seg 7F with dp_out 1 during frames 2-3, 6-7, ...; normal with dp_out 0 otherwise.
REQ-041 Boundary events: load coincident with frame wrap -> value appears one frame later; rst=0 mid-frame with pending load -> REQ-031/032 values, no load_ack.
